// File: rtl/uart_mutex_requester_pkg.sv
// Shared constants, operation words and FSM state encoding for the UART mutex requester.
package uart_mutex_pkg;

    localparam logic [15:0] START_BASE = 16'hFBFF;
    localparam logic [15:0] STOP_WORD  = 16'hFB00;
    localparam logic [15:0] IDLE_WORD  = 16'h0000;
    localparam logic [7:0]  DATA_TAG   = 8'h01;
    localparam logic [1:0]  LOCK_NODE0 = 2'b00;
    localparam logic [1:0]  LOCK_NODE1 = 2'b01;
    localparam logic [1:0]  LOCK_FREE  = 2'b11;
    localparam logic [7:0]  IRQ_BYTE   = 8'h4E;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQUEST,
        ST_OWNED,
        ST_RELEASE
    } state_t;

    function automatic logic [15:0] request_word(input logic [3:0] prio);
        return START_BASE ^ {12'h000, prio};
    endfunction

endpackage

// File: rtl/uart_mutex_requester_if.sv
// Host and arbiter-facing signals of the requester; master is the requester, slave its environment.
interface uart_mutex_requester_if;
    logic        req_valid;
    logic [3:0]  req_prio;
    logic        release_req;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic [15:0] op_out;
    logic [1:0]  lock_state;
    logic [15:0] sync_in;
    logic        irq_in;
    logic        granted;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        irq_out;
    logic        err;

    modport master (
        input  req_valid, req_prio, release_req, tx_valid, tx_data, lock_state, sync_in, irq_in,
        output tx_ready, op_out, granted, rx_valid, rx_data, irq_out, err
    );

    modport slave (
        output req_valid, req_prio, release_req, tx_valid, tx_data, lock_state, sync_in, irq_in,
        input  tx_ready, op_out, granted, rx_valid, rx_data, irq_out, err
    );
endinterface

// File: rtl/uart_mutex_requester_ctr.sv
// Abort timer: counts while enabled, tc is high in the enabled cycle where the count is LIMIT-1.
module mutex_timeout_ctr #(
    parameter int  LIMIT = 1024,
    localparam int W     = (LIMIT > 1) ? $clog2(LIMIT) : 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tc
);
    localparam logic [W-1:0] LAST = W'(LIMIT - 1);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + W'(1);
        end
    end

    assign tc = enable && (count == LAST);
endmodule

// File: rtl/uart_mutex_requester.sv
// Requester side of a two-node UART mutex: acquires the arbiter lock, forwards host bytes, returns tagged replies.
// All outputs registered; at most one host byte per two cycles, replies surface two cycles after their data word.
module uart_mutex_requester
    import uart_mutex_pkg::*;
#(
    parameter int NODE_ID       = 0,
    parameter int GRANT_TIMEOUT = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    uart_mutex_requester_if.master bus
);
    localparam logic [1:0] OWN_LOCK = (NODE_ID == 0) ? LOCK_NODE0 : LOCK_NODE1;
    localparam logic [7:0] OWN_TAG  = 8'(NODE_ID + 1);

    state_t      state, next_state;
    logic [3:0]  prio_q, prio_nx;
    logic [15:0] op_q, op_nx;
    logic        granted_q, granted_nx, tx_ready_q, tx_ready_nx;
    logic        rx_valid_q, rx_valid_nx, irq_out_q, irq_out_nx, err_q, err_nx;
    logic [7:0]  rx_data_q, rx_data_nx;
    logic        data_word_q, data_word_nx;
    logic        rx_pend_q, rx_pend_nx;
    logic        rel_pend_q, rel_pend_nx;
    logic        irq_in_q;
    logic        lock_ok, accept, tmr_en, tmr_clr, tmr_tc;

    mutex_timeout_ctr #(.LIMIT(GRANT_TIMEOUT)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (tmr_clr),
        .enable (tmr_en),
        .tc     (tmr_tc)
    );

    always_comb begin
        next_state   = state;
        prio_nx      = prio_q;
        op_nx        = IDLE_WORD;
        tx_ready_nx  = 1'b0;
        rx_valid_nx  = 1'b0;
        rx_data_nx   = rx_data_q;
        irq_out_nx   = 1'b0;
        err_nx       = 1'b0;
        data_word_nx = 1'b0;
        rx_pend_nx   = 1'b0;
        rel_pend_nx  = 1'b0;
        accept       = 1'b0;
        lock_ok      = (bus.lock_state == OWN_LOCK);
        tmr_en       = (state == ST_REQUEST) || (state == ST_RELEASE);
        tmr_clr      = !tmr_en;

        unique case (state)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    prio_nx    = (bus.req_prio == 4'd0) ? 4'd1 : bus.req_prio;
                    op_nx      = request_word(prio_nx);
                    next_state = ST_REQUEST;
                end
            end
            ST_REQUEST: begin
                if (lock_ok) begin
                    next_state  = ST_OWNED;
                    tx_ready_nx = 1'b1;
                end else if (tmr_tc) begin
                    err_nx     = 1'b1;
                    next_state = ST_IDLE;
                end else begin
                    op_nx = request_word(prio_q);
                end
            end
            ST_OWNED: begin
                if (!lock_ok) begin
                    // Ownership lost: any reply still in flight is dropped.
                    err_nx     = 1'b1;
                    next_state = ST_IDLE;
                end else begin
                    accept      = bus.tx_valid && tx_ready_q;
                    rel_pend_nx = rel_pend_q || bus.release_req;
                    rx_pend_nx  = data_word_q;
                    irq_out_nx  = bus.irq_in && !irq_in_q;
                    if (rx_pend_q && (bus.sync_in[15:8] == OWN_TAG)) begin
                        rx_valid_nx = 1'b1;
                        rx_data_nx  = bus.sync_in[7:0];
                    end
                    if (accept) begin
                        op_nx        = {DATA_TAG, bus.tx_data};
                        data_word_nx = 1'b1;
                    end else if (rel_pend_nx && !data_word_q && !rx_pend_q) begin
                        op_nx       = STOP_WORD;
                        rel_pend_nx = 1'b0;
                        next_state  = ST_RELEASE;
                    end
                    // A pending release stops new bytes so it cannot be deferred forever.
                    tx_ready_nx = (next_state == ST_OWNED) && !accept && !rel_pend_nx;
                end
            end
            ST_RELEASE: begin
                if (bus.lock_state == LOCK_FREE) begin
                    next_state = ST_IDLE;
                end else if (tmr_tc) begin
                    err_nx     = 1'b1;
                    next_state = ST_IDLE;
                end else begin
                    op_nx = STOP_WORD;
                end
            end
            default: next_state = ST_IDLE;
        endcase

        granted_nx = (next_state == ST_OWNED);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            prio_q      <= 4'd1;
            op_q        <= IDLE_WORD;
            granted_q   <= 1'b0;
            tx_ready_q  <= 1'b0;
            rx_valid_q  <= 1'b0;
            rx_data_q   <= 8'h00;
            irq_out_q   <= 1'b0;
            err_q       <= 1'b0;
            data_word_q <= 1'b0;
            rx_pend_q   <= 1'b0;
            rel_pend_q  <= 1'b0;
            irq_in_q    <= 1'b0;
        end else begin
            state       <= next_state;
            prio_q      <= prio_nx;
            op_q        <= op_nx;
            granted_q   <= granted_nx;
            tx_ready_q  <= tx_ready_nx;
            rx_valid_q  <= rx_valid_nx;
            rx_data_q   <= rx_data_nx;
            irq_out_q   <= irq_out_nx;
            err_q       <= err_nx;
            data_word_q <= data_word_nx;
            rx_pend_q   <= rx_pend_nx;
            rel_pend_q  <= rel_pend_nx;
            irq_in_q    <= bus.irq_in;
        end
    end

    assign bus.op_out   = op_q;
    assign bus.granted  = granted_q;
    assign bus.tx_ready = tx_ready_q;
    assign bus.rx_valid = rx_valid_q;
    assign bus.rx_data  = rx_data_q;
    assign bus.irq_out  = irq_out_q;
    assign bus.err      = err_q;
endmodule

// File: doc/uart_mutex_requester.md
UART_MUTEX_REQUESTER -- requirements
Module: uart_mutex_requester

Interface
REQ-001 Parameter NODE_ID, default 0, SHALL select the node slot served (0 or 1); its own lock code is NODE_ID, its tag byte is NODE_ID+1.
REQ-002 Parameter GRANT_TIMEOUT, default 1024, SHALL be the maximum cycles spent in REQUEST or RELEASE before abort.
REQ-003 CLK  in  1  sole clock, all state on rising edge.
REQ-004 RST  in  1  reset, asynchronous, active-high.
REQ-005 req_valid  in  1  host requests UART ownership.
REQ-006 req_prio  in  4  request priority; 15 highest.
REQ-007 release  in  1  host ends ownership.
REQ-008 tx_valid / tx_data  in  1 / 8  host byte to peripheral.
REQ-009 tx_ready  out  1  byte accepted when tx_valid and tx_ready are both high.
REQ-010 op_out  out  16  operation word to arbiter node port.
REQ-011 lock_state  in  2  arbiter lock: 00 node0, 01 node1, 11 free.
REQ-012 sync_in  in  16  arbiter return word {tag, peripheral byte}.
REQ-013 irq_in  in  1  arbiter IRQ line for this node.
REQ-014 granted, rx_valid, irq_out, err  out  1 each; rx_data  out  8.

Function
REQ-015 FSM states SHALL be IDLE, REQUEST, OWNED, RELEASE; op_out and all outputs SHALL be registered.
REQ-016 IDLE: op_out=16'h0000; on req_valid, latch prio (0 replaced by 1), clear timer, go to REQUEST.
REQ-017 REQUEST: op_out SHALL be 16'hFBFF XOR {12'h000, prio}; timer increments each cycle.
REQ-018 REQUEST with lock_state==NODE_ID SHALL go to OWNED next cycle; op_out=16'h0000 in that first OWNED cycle.
REQ-019 REQUEST with lock_state held by the other node SHALL keep requesting (timer still running).
REQ-020 REQUEST timer reaching GRANT_TIMEOUT-1 SHALL pulse err one cycle, drive 16'h0000, return to IDLE.
REQ-021 OWNED: granted=1; tx_ready=1 only when no byte was accepted in the previous cycle (max one byte per 2 cycles).
REQ-022 Accepted byte SHALL appear as op_out={8'h01, tx_data} for exactly one cycle, followed by 16'h0000.
REQ-023 rx_valid SHALL pulse exactly 2 cycles after each data-word cycle iff sync_in[15:8]==NODE_ID+1, with rx_data=sync_in[7:0]; no pulse otherwise.
REQ-024 irq_out SHALL pulse one cycle on each rising edge of irq_in while in OWNED; ignored in other states.
REQ-025 release in OWNED SHALL be honoured only when no data word is on op_out and no rx_valid is pending; otherwise deferred until both clear.
REQ-026 RELEASE: op_out=16'hFB00; on lock_state==2'b11 go to IDLE with op_out=16'h0000; timer timeout SHALL pulse err and go to IDLE.
REQ-027 OWNED with lock_state!=NODE_ID SHALL pulse err, drop granted, go to IDLE; in-flight rx pulse suppressed.
REQ-028 req_valid in non-IDLE states SHALL be ignored; tx_valid outside OWNED SHALL never be accepted.
REQ-029 req_valid and release both high in IDLE: request taken, release ignored.

Reset
REQ-030 RST high SHALL immediately force IDLE, op_out=16'h0000, granted=tx_ready=rx_valid=irq_out=err=0, rx_data=8'h00, timer=0.
REQ-031 RST mid-OWNED SHALL NOT emit a stop word; arbiter recovery is system responsibility.
REQ-032 First request SHALL be accepted on the first rising edge after RST deasserts.

Structure
REQ-033 Shared package uart_mutex_pkg SHALL hold START_BASE 16'hFBFF, STOP_WORD 16'hFB00, IDLE_WORD 16'h0000, DATA_TAG 8'h01, lock codes 00/01/11, IRQ byte 8'h4E, FSM state enum.
REQ-034 Timer SHALL be one sub-module, mutex_timeout_ctr (clear, enable, terminal-count pulse), width clog2(GRANT_TIMEOUT).

Verification
REQ-035 req_valid, prio=4'hA, lock_state 11->00 after 3 cycles -> op_out=16'hFBF5 for 3 cycles, then 16'h0000, granted=1.
REQ-036 OWNED, tx_data=8'h41, sync_in={8'h01,8'h4E} returned -> op_out=16'h0141 one cycle, rx_valid 2 cycles later with rx_data=8'h4E.
REQ-037 release in OWNED, lock_state->11 after 2 cycles -> op_out=16'hFB00 for 2 cycles, then IDLE, granted=0.
REQ-038 lock_state stuck at 01 for GRANT_TIMEOUT=16 -> err pulse at cycle 16, op_out=16'h0000, IDLE.
REQ-039 prio=0 -> op_out=16'hFBFE; RST asserted mid-OWNED -> all outputs zero same cycle, no FB00 word.
REQ-040 irq_in held high 5 cycles in OWNED -> single irq_out pulse; sync_in tag 8'h02 with NODE_ID=0 -> no rx_valid.
